// File: rtl/banked_mem_resp.sv
// Four-bank 16-bit word memory with per-bank occupancy timers and a fixed
// two-cycle read response pipeline. Same-bank requests stall while the bank is busy.
module banked_mem_resp #(
  parameter int ADDR_W     = 16,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       data_in,
  output logic [15:0]       data_out,
  output logic              data_valid,
  output logic              stall,
  output logic [3:0]        busy,
  output logic              err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [15:0]           mem [4][DEPTH];
  logic [2:0]            cnt [4];
  logic [1:0]            bank;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  req;
  logic                  accept;
  logic                  s1_valid;
  logic [15:0]           s1_data;

  assign bank = addr[2:1];
  assign idx  = addr[DEPTH_LOG2+2:3];

  // Address bits above the word index alias onto the same words.
  generate
    if (ADDR_W > DEPTH_LOG2 + 3) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^addr[ADDR_W-1:DEPTH_LOG2+3];
    end
  endgenerate

  // Per-bank busy flags derived from the occupancy counters.
  always_comb begin
    busy = 4'b0000;
    for (int b = 0; b < 4; b++) begin
      busy[b] = (cnt[b] != 3'd0);
    end
  end

  // Request classification; an illegal request never stalls.
  always_comb begin
    req    = rd | wr;
    err    = req & ((rd & wr) | addr[0]);
    stall  = req & ~err & busy[bank];
    accept = req & ~err & ~stall;
  end

  // Occupancy counters: load 4 on accept, otherwise count down to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 4; b++) begin
        cnt[b] <= 3'd0;
      end
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (accept && (bank == 2'(b))) begin
          cnt[b] <= 3'd4;
        end else if (cnt[b] != 3'd0) begin
          cnt[b] <= cnt[b] - 3'd1;
        end else begin
          cnt[b] <= 3'd0;
        end
      end
    end
  end

  // Bank storage write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (!rst && accept && wr) begin
      mem[bank][idx] <= data_in;
    end
  end

  // Two-stage read response pipeline; data_out holds between responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_data    <= 16'h0000;
      data_valid <= 1'b0;
      data_out   <= 16'h0000;
    end else begin
      s1_valid <= accept & rd;
      if (accept && rd) begin
        s1_data <= mem[bank][idx];
      end
      data_valid <= s1_valid;
      if (s1_valid) begin
        data_out <= s1_data;
      end
    end
  end

endmodule

// File: tb/tb_banked_mem_resp.sv
// Bench for banked_mem_resp: directed vector table, a reset sequence, and
// randomized traffic checked against a timestamp/queue reference model.
module tb_banked_mem_resp;

  logic        clk = 1'b0;
  logic        rst, rd, wr;
  logic [15:0] addr, data_in, data_out;
  logic        data_valid, stall, err;
  logic [3:0]  busy;

  int n_cmp  = 0;
  int n_fail = 0;

  banked_mem_resp #(.ADDR_W(16), .DEPTH_LOG2(8)) dut (
    .clk(clk), .rst(rst), .rd(rd), .wr(wr), .addr(addr), .data_in(data_in),
    .data_out(data_out), .data_valid(data_valid), .stall(stall), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        t_rd;
    logic        t_wr;
    logic [15:0] t_addr;
    logic [15:0] t_din;
    logic        e_err;
    logic        e_stall;
    logic [3:0]  e_busy;
    logic        e_dv;
    logic [15:0] e_dout;
  } vec_t;

  vec_t tbl[$];

  typedef struct {
    int          due;
    logic [15:0] data;
    bit          known;
  } rd_t;

  rd_t         pend[$];
  logic [15:0] ref_mem [int];
  int          free_at [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
    rd = r; wr = w; addr = a; data_in = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d,
                     input logic e, input logic s, input logic [3:0] b, input logic v,
                     input logic [15:0] o);
    vec_t x;
    x.t_rd = r; x.t_wr = w; x.t_addr = a; x.t_din = d;
    x.e_err = e; x.e_stall = s; x.e_busy = b; x.e_dv = v; x.e_dout = o;
    tbl.push_back(x);
  endtask

  task automatic idle(input logic [3:0] b, input logic v, input logic [15:0] o);
    add(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, b, v, o);
  endtask

  initial begin
    logic        hold, exp_dv, exp_err, exp_stall, m_known, r_rst;
    logic [3:0]  exp_busy;
    logic [15:0] m_dout, a;
    int          cyc, bk, key, op;
    rd_t         ent;

    rst = 1'b1;
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    tick(); tick();
    rst = 1'b0;

    // Write then read back one word (rows 0-9)
    add(1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 1'b0, 4'b0000, 1'b0, 16'h0000);
    for (int i = 0; i < 4; i++) idle(4'b0001, 1'b0, 16'h0000);
    add(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 4'b0000, 1'b0, 16'h0000);
    idle(4'b0001, 1'b0, 16'h0000);
    idle(4'b0001, 1'b1, 16'hBEEF);
    idle(4'b0001, 1'b0, 16'hBEEF);
    idle(4'b0001, 1'b0, 16'hBEEF);
    // Fill one word per bank, then read them back to back (rows 10-25)
    add(1'b0, 1'b1, 16'h0000, 16'h1111, 1'b0, 1'b0, 4'b0000, 1'b0, 16'hBEEF);
    add(1'b0, 1'b1, 16'h0002, 16'h2222, 1'b0, 1'b0, 4'b0001, 1'b0, 16'hBEEF);
    add(1'b0, 1'b1, 16'h0004, 16'h3333, 1'b0, 1'b0, 4'b0011, 1'b0, 16'hBEEF);
    add(1'b0, 1'b1, 16'h0006, 16'h4444, 1'b0, 1'b0, 4'b0111, 1'b0, 16'hBEEF);
    idle(4'b1111, 1'b0, 16'hBEEF);
    idle(4'b1110, 1'b0, 16'hBEEF);
    idle(4'b1100, 1'b0, 16'hBEEF);
    idle(4'b1000, 1'b0, 16'hBEEF);
    add(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 4'b0000, 1'b0, 16'hBEEF);
    add(1'b1, 1'b0, 16'h0002, 16'h0000, 1'b0, 1'b0, 4'b0001, 1'b0, 16'hBEEF);
    add(1'b1, 1'b0, 16'h0004, 16'h0000, 1'b0, 1'b0, 4'b0011, 1'b1, 16'h1111);
    add(1'b1, 1'b0, 16'h0006, 16'h0000, 1'b0, 1'b0, 4'b0111, 1'b1, 16'h2222);
    idle(4'b1111, 1'b1, 16'h3333);
    idle(4'b1110, 1'b1, 16'h4444);
    idle(4'b1100, 1'b0, 16'h4444);
    idle(4'b1000, 1'b0, 16'h4444);
    // Same-bank read stalls for four cycles (rows 26-36)
    add(1'b0, 1'b1, 16'h0008, 16'h5555, 1'b0, 1'b0, 4'b0000, 1'b0, 16'h4444);
    for (int i = 0; i < 4; i++) idle(4'b0001, 1'b0, 16'h4444);
    add(1'b1, 1'b0, 16'h0008, 16'h0000, 1'b0, 1'b0, 4'b0000, 1'b0, 16'h4444);
    add(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b1, 4'b0001, 1'b0, 16'h4444);
    add(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b1, 4'b0001, 1'b1, 16'h5555);
    add(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b1, 4'b0001, 1'b0, 16'h5555);
    add(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b1, 4'b0001, 1'b0, 16'h5555);
    add(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 4'b0000, 1'b0, 16'h5555);
    // Illegal requests, one aimed at a busy bank (rows 37-41)
    add(1'b1, 1'b1, 16'h0010, 16'h0000, 1'b1, 1'b0, 4'b0001, 1'b0, 16'h5555);
    add(1'b1, 1'b0, 16'h0003, 16'h0000, 1'b1, 1'b0, 4'b0001, 1'b1, 16'hBEEF);
    idle(4'b0001, 1'b0, 16'hBEEF);
    idle(4'b0001, 1'b0, 16'hBEEF);
    idle(4'b0000, 1'b0, 16'hBEEF);

    foreach (tbl[i]) begin
      drive(tbl[i].t_rd, tbl[i].t_wr, tbl[i].t_addr, tbl[i].t_din);
      @(negedge clk);
      chk($sformatf("vec%0d.err", i), 32'(err), 32'(tbl[i].e_err));
      chk($sformatf("vec%0d.stall", i), 32'(stall), 32'(tbl[i].e_stall));
      chk($sformatf("vec%0d.busy", i), 32'(busy), 32'(tbl[i].e_busy));
      chk($sformatf("vec%0d.data_valid", i), 32'(data_valid), 32'(tbl[i].e_dv));
      chk($sformatf("vec%0d.data_out", i), 32'(data_out), 32'(tbl[i].e_dout));
      tick();
    end

    // Read in flight when reset hits, then a fresh read afterwards
    drive(1'b1, 1'b0, 16'h0010, 16'h0000);
    @(negedge clk);
    chk("rstseq.stall_pre", 32'(stall), 32'd0);
    tick();
    rst = 1'b1;
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    @(negedge clk);
    chk("rstseq.busy_inflight", 32'(busy), 32'h1);
    tick();
    rst = 1'b0;
    drive(1'b1, 1'b0, 16'h0010, 16'h0000);
    @(negedge clk);
    chk("rstseq.dv_after", 32'(data_valid), 32'd0);
    chk("rstseq.dout_after", 32'(data_out), 32'h0);
    chk("rstseq.busy_after", 32'(busy), 32'h0);
    chk("rstseq.stall_after", 32'(stall), 32'd0);
    tick();
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    @(negedge clk);
    chk("rstseq.dv_t1", 32'(data_valid), 32'd0);
    tick();
    @(negedge clk);
    chk("rstseq.dv_t2", 32'(data_valid), 32'd1);
    chk("rstseq.dout_t2", 32'(data_out), 32'hBEEF);
    tick();

    // Randomized traffic against the reference model
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cyc = 0;
    for (int b = 0; b < 4; b++) free_at[b] = 0;
    m_dout = 16'h0000;
    m_known = 1'b1;
    hold = 1'b0;
    for (int k = 0; k < 1500; k++) begin
      if (hold) begin
        rst = 1'b0;
      end else begin
        r_rst = ($urandom_range(0, 79) == 0);
        op = $urandom_range(0, 9);
        a = 16'($urandom);
        a[10:3] = 8'($urandom_range(0, 3));
        a[0] = ($urandom_range(0, 15) == 0);
        rst = r_rst;
        drive(op >= 3 && op != 6 && op != 7 && op != 8, op >= 6, a, 16'($urandom));
      end
      @(negedge clk);
      exp_dv = 1'b0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        ent = pend.pop_front();
        exp_dv = 1'b1;
        m_dout = ent.data;
        m_known = ent.known;
      end
      for (int b = 0; b < 4; b++) exp_busy[b] = (cyc < free_at[b]);
      bk = int'(addr) / 2 % 4;
      exp_err = (rd || wr) && ((rd && wr) || (int'(addr) % 2 == 1));
      exp_stall = (rd || wr) && !exp_err && exp_busy[bk];
      chk("rand.err", 32'(err), 32'(exp_err));
      chk("rand.stall", 32'(stall), 32'(exp_stall));
      chk("rand.busy", 32'(busy), 32'(exp_busy));
      chk("rand.data_valid", 32'(data_valid), 32'(exp_dv));
      if (m_known) chk("rand.data_out", 32'(data_out), 32'(m_dout));
      if (rst) begin
        pend.delete();
        for (int b = 0; b < 4; b++) free_at[b] = 0;
        m_dout = 16'h0000;
        m_known = 1'b1;
      end else if ((rd || wr) && !exp_err && !exp_stall) begin
        free_at[bk] = cyc + 5;
        key = int'(addr) / 2 % 1024;
        if (wr) begin
          ref_mem[key] = data_in;
        end else begin
          ent.due = cyc + 2;
          ent.known = ref_mem.exists(key);
          ent.data = ent.known ? ref_mem[key] : 16'h0000;
          pend.push_back(ent);
        end
      end
      hold = exp_stall && !rst;
      tick();
      cyc++;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/banked_mem_resp.md
BANKED_MEM_RESP -- requirements
Module: banked_mem_resp

Interface
REQ-001 Parameter: ADDR_W, default 16, byte-address width; word = 16 bits, addr[0] is the byte select.
REQ-002 Parameter: DEPTH_LOG2, default 8, log2 of words per bank; bank word index = addr[DEPTH_LOG2+2:3].
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: rd  input  1  read request, sampled every cycle.
REQ-006 Port: wr  input  1  write request, sampled every cycle.
REQ-007 Port: addr  input  ADDR_W  byte address; bank = addr[2:1].
REQ-008 Port: data_in  input  16  write data.
REQ-009 Port: data_out  output  16  read data, registered.
REQ-010 Port: data_valid  output  1  data_out holds returned read data this cycle.
REQ-011 Port: stall  output  1  combinational; request not accepted this cycle, requester must hold rd/wr/addr/data_in.
REQ-012 Port: busy  output  4  per-bank busy flags, busy[b] for bank b.
REQ-013 Port: err  output  1  combinational; illegal request this cycle.

Function
REQ-014 Storage: four independent banks, each 2^DEPTH_LOG2 x 16 bits; bank contents not reset.
REQ-015 Request present: req = rd | wr.
REQ-016 err = req & ((rd & wr) | addr[0]); an err request performs no access, loads no counter, and does not assert stall.
REQ-017 stall = req & ~err & busy[addr[2:1]].
REQ-018 Accept in cycle T: req & ~err & ~stall.
REQ-019 Each bank has a 3-bit occupancy counter; on accept, the selected bank counter loads 4; otherwise a nonzero counter decrements by 1 per cycle; busy[b] = (counter_b != 0).
REQ-020 A bank accepted at T shows busy in cycles T+1..T+4 and can accept again at T+5.
REQ-021 Different banks are independent; one accept per cycle maximum, so back-to-back accepts to bank 0,1,2,3 in consecutive cycles all succeed without stall.
REQ-022 Write accept at T: data_in is written to the selected bank word at the end of T.
REQ-023 Read accept at T: the array word is sampled at T and travels through a 2-stage valid/data pipeline; data_out and data_valid are driven in cycle T+2.
REQ-024 Fixed read latency = 2 cycles, independent of bank or traffic; pipeline never stalls.
REQ-025 When no read completes in a cycle, data_valid = 0 and data_out holds its previous value.
REQ-026 Write accepts create no pipeline entry; data_valid is never asserted for a write.
REQ-027 A read of a word written by an earlier accept always returns the written data; same-bank hazards are prevented by busy.
REQ-028 Stalled and err requests leave all state unchanged except the normal counter decrements.

Reset
REQ-029 When rst is high at a rising edge: all bank counters = 0, busy = 4'b0000, both pipeline valids = 0, data_valid = 0, data_out = 16'h0000.
REQ-030 When rst is high, no request is accepted and no write is performed; in-flight reads are discarded, and data_valid stays 0 in the first cycle after rst deasserts.
REQ-031 stall and err follow REQ-016/017 from reset state, so stall = 0 in the first cycle after reset.

Verification
REQ-032 Write 16'hBEEF to addr 16'h0010 (bank 0) at T -> busy = 4'b0001 during T+1..T+4 and 4'b0000 at T+5; read of 16'h0010 at T+5 -> data_valid = 1, data_out = 16'hBEEF at T+7.
REQ-033 Reads to 16'h0000, 0002, 0004, 0006 in four consecutive cycles -> no stall, four consecutive data_valid pulses in bank order starting two cycles after the first read.
REQ-034 Read 16'h0008 (bank 0) at T, then another bank-0 read held from T+1 -> stall = 1 during T+1..T+4, accept at T+5, data_valid at T+7.
REQ-035 rd=wr=1 at T, and separately rd with addr 16'h0003 -> err = 1, stall = 0, busy unchanged, no data_valid.
REQ-036 Read accepted at T, rst asserted at T+1 -> data_valid = 0 at T+2, busy = 0 after reset, and a fresh read after reset succeeds with 2-cycle latency.
